adder: RTL and testbench



---
 rtl/adder.sv | 32 +++
 tb/tb_adder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Unsigned n-bit ripple-carry adder with a registered (n+1)-bit sum.
// The carry-out is the MSB of final_sum. The sum appears one clock after the operands.
module adder #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] augend,
  input  logic [n-1:0] addend,
  output logic [n:0]   final_sum
);

  logic [n:0]   c;
  logic [n-1:0] s;
  logic [n-1:0] p;

  assign c[0] = 1'b0;

  // Ripple chain: stage i propagates a carry when exactly one operand bit is set
  for (genvar i = 0; i < n; i++) begin : g_fa
    assign p[i]   = augend[i] ^ addend[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = (augend[i] & addend[i]) | (c[i] & p[i]);
  end

  // Stage boundary: output register, no enable
  always_ff @(posedge clk) begin
    if (rst) final_sum <= '0;
    else     final_sum <= {c[n], s};
  end

endmodule

// File: tb/tb_adder.sv
// Bench for adder: n=4 and n=8 instances checked every cycle against an arithmetic model,
// plus directed vectors with literal expected sums.
module tb_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic [4:0] sum4;
  logic [8:0] sum8;

  int checks = 0;
  int fails  = 0;

  logic [4:0] exp4;
  logic [8:0] exp8;
  logic       model_vld = 1'b0;

  adder #(.n(4)) dut4 (.clk(clk), .rst(rst), .augend(a4), .addend(b4), .final_sum(sum4));
  adder #(.n(8)) dut8 (.clk(clk), .rst(rst), .augend(a8), .addend(b8), .final_sum(sum8));

  always #5 clk = ~clk;

  // Model: the registered output is the plain integer sum of the operands seen at the edge
  always @(posedge clk) begin
    if (rst) begin
      exp4 = 5'd0;
      exp8 = 9'd0;
    end else begin
      exp4 = 5'(int'(a4) + int'(b4));
      exp8 = 9'(int'(a8) + int'(b8));
    end
    model_vld = 1'b1;
  end

  // Every-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (model_vld) begin
      checks++;
      if (sum4 !== exp4) begin
        fails++;
        $display("FAIL model_n4 t=%0t: got %h expected %h", $time, sum4, exp4);
      end
      checks++;
      if (sum8 !== exp8) begin
        fails++;
        $display("FAIL model_n8 t=%0t: got %h expected %h", $time, sum8, exp8);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lit4(input string name, input logic [4:0] want);
    checks++;
    if (sum4 !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, sum4, want);
    end
  endtask

  task automatic lit8(input string name, input logic [8:0] want);
    checks++;
    if (sum8 !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, sum8, want);
    end
  endtask

  task automatic vec4(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic [4:0] want);
    a4 = a;
    b4 = b;
    tick();
    lit4(name, want);
  endtask

  task automatic vec8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [8:0] want);
    a8 = a;
    b8 = b;
    tick();
    lit8(name, want);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a4  = 4'hF;
    b4  = 4'hF;
    a8  = 8'hFF;
    b8  = 8'hFF;
    tick();
    tick();
    lit4("reset_n4", 5'b00000);
    lit8("reset_n8", 9'h000);

    rst = 1'b0;
    tick();
    lit4("release_ff_ff", 5'b11110);

    vec4("zero",        4'b0000, 4'b0000, 5'b00000);
    vec4("ident_aug",   4'b0101, 4'b0000, 5'b00101);
    vec4("ident_add",   4'b0000, 4'b1010, 5'b01010);
    vec4("wrap_f_1",    4'b1111, 4'b0001, 5'b10000);
    vec4("ripple_7_1",  4'b0111, 4'b0001, 5'b01000);
    vec4("max_f_f",     4'b1111, 4'b1111, 5'b11110);
    vec4("mixed_9_6",   4'b1001, 4'b0110, 5'b01111);

    // Reset in the middle of a stream
    rst = 1'b1;
    tick();
    lit4("mid_reset", 5'b00000);
    rst = 1'b0;
    vec4("after_reset", 4'b0011, 4'b0100, 5'b00111);

    // Exhaustive n=4 sweep, checked by the model process each cycle
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i);
        b4 = 4'(j);
        tick();
      end
    end

    vec8("n8_ff_01", 8'hFF, 8'h01, 9'h100);
    vec8("n8_ff_ff", 8'hFF, 8'hFF, 9'h1FE);
    vec8("n8_80_80", 8'h80, 8'h80, 9'h100);
    vec8("n8_12_34", 8'h12, 8'h34, 9'h046);

    for (int k = 0; k < 1000; k++) begin
      a8 = 8'($urandom_range(255));
      b8 = 8'($urandom_range(255));
      a4 = 4'($urandom_range(15));
      b4 = 4'($urandom_range(15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
